// File: rtl/data_bus_pkg.sv
// data_bus_pkg: shared master IDs, arbiter state and default widths for the data bus.
package data_bus_pkg;
  typedef logic master_id_t;
  typedef enum logic {ARB_FREE = 1'b0, ARB_LOCKED = 1'b1} arb_state_t;
  localparam int NUM_MASTERS = 2;
  localparam master_id_t M_CORE = 1'b0;
  localparam master_id_t M_AUX = 1'b1;
  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
endpackage

// File: rtl/id_fifo.sv
// id_fifo: in-order FIFO of master IDs for accepted-but-unanswered transactions.
module id_fifo
  import data_bus_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  master_id_t    din,
  output master_id_t    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  master_id_t mem_q [DEPTH];
  master_id_t mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    full = cnt_q == CW'(DEPTH);
    empty = cnt_q == '0;
    dout = mem_q[rd_q];
    count = cnt_q;
    do_push = push & !full;
    do_pop = pop & !empty;
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d = do_push ? inc(wr_q) : wr_q;
    rd_d = do_pop ? inc(rd_q) : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin two-master arbiter onto one req/gnt/rvalid memory port,
// routing in-order responses back through an ID FIFO.
module data_mem_arbiter
  import data_bus_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W,
  parameter int MAX_OUTSTANDING = 2,
  localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic                m0_we,
  input  logic [DATA_W/8-1:0] m0_be,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic                m1_we,
  input  logic [DATA_W/8-1:0] m1_be,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_req,
  output logic [ADDR_W-1:0]   s_addr,
  output logic                s_we,
  output logic [DATA_W/8-1:0] s_be,
  output logic [DATA_W-1:0]   s_wdata,
  input  logic                s_gnt,
  input  logic                s_rvalid,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic [OW-1:0]       outstanding,
  output logic                err_unexpected
);
  arb_state_t state_q, state_d;
  master_id_t lock_id_q, lock_id_d, rr_last_q, rr_last_d, sel, head;
  logic err_q, err_d, full, empty, hs, pop, sel_req;
  always_comb begin
    sel = state_q == ARB_LOCKED ? lock_id_q : (m0_req ^ m1_req) ? master_id_t'(m1_req) : !rr_last_q;
    sel_req = sel == M_AUX ? m1_req : m0_req;
    // Combinational outputs are gated by reset so the port is quiet while held in reset.
    s_req = HRESETn & sel_req & !full;
    hs = s_req & s_gnt;
    pop = HRESETn & s_rvalid & !empty;
    s_addr = s_req ? (sel == M_AUX ? m1_addr : m0_addr) : '0;
    s_we = s_req & (sel == M_AUX ? m1_we : m0_we);
    s_be = s_req ? (sel == M_AUX ? m1_be : m0_be) : '0;
    s_wdata = s_req ? (sel == M_AUX ? m1_wdata : m0_wdata) : '0;
    m0_gnt = hs & (sel == M_CORE);
    m1_gnt = hs & (sel == M_AUX);
    m0_rvalid = pop & (head == M_CORE);
    m1_rvalid = pop & (head == M_AUX);
    m0_rdata = m0_rvalid ? s_rdata : '0;
    m1_rdata = m1_rvalid ? s_rdata : '0;
    err_unexpected = err_q;
    state_d = state_q;
    lock_id_d = lock_id_q;
    rr_last_d = rr_last_q;
    err_d = err_q | (s_rvalid & empty);
    if (hs) begin
      state_d = ARB_FREE;
      rr_last_d = sel;
    end else if (s_req) begin
      state_d = ARB_LOCKED;
      lock_id_d = sel;
    end else if (state_q == ARB_LOCKED && !sel_req) begin
      state_d = ARB_FREE;
    end
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ARB_FREE;
      lock_id_q <= M_CORE;
      rr_last_q <= M_AUX;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_id_q <= lock_id_d;
      rr_last_q <= rr_last_d;
      err_q <= err_d;
    end
  end
  id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_ids (
    .clk(HCLK),
    .rst_n(HRESETn),
    .push(hs),
    .pop(pop),
    .din(sel),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(outstanding)
  );
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_data_mem_arbiter;
  localparam int MAXO = 2;
  logic HCLK = 0, HRESETn = 0;
  logic m0_req, m0_we, m1_req, m1_we, s_gnt, s_rvalid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
  logic [3:0] m0_be, m1_be;
  logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, s_req, s_we, err_unexpected;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0] s_be;
  logic [1:0] outstanding;
  int total = 0, bad = 0;
  bit mq[$];
  bit m_rr = 1, m_lk = 0, m_lkid = 0, m_err = 0;

  typedef struct packed {
    logic s_req, g0, g1, v0, v1;
    logic [31:0] rd0, rd1, addr, wdata;
    logic we;
    logic [3:0] be;
    logic [1:0] outs;
    logic err;
  } exp_t;

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(MAXO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_be(m0_be), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_be(m1_be), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_be(s_be), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .outstanding(outstanding), .err_unexpected(err_unexpected)
  );

  always #5 HCLK = ~HCLK;

  function automatic bit msel();
    if (m_lk) return m_lkid;
    if (m0_req && !m1_req) return 0;
    if (m1_req && !m0_req) return 1;
    return !m_rr;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    bit sel;
    e = '0;
    if (!HRESETn) return e;
    sel = msel();
    e.s_req = (sel ? m1_req : m0_req) && mq.size() < MAXO;
    if (e.s_req) begin
      e.addr = sel ? m1_addr : m0_addr;
      e.wdata = sel ? m1_wdata : m0_wdata;
      e.we = sel ? m1_we : m0_we;
      e.be = sel ? m1_be : m0_be;
      e.g0 = s_gnt && !sel;
      e.g1 = s_gnt && sel;
    end
    if (s_rvalid && mq.size() > 0) begin
      e.v0 = !mq[0];
      e.v1 = mq[0];
      if (mq[0]) e.rd1 = s_rdata;
      else e.rd0 = s_rdata;
    end
    e.outs = 2'(mq.size());
    e.err = m_err;
    return e;
  endfunction

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_be = 4'hF; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_be = 4'hF; m1_addr = 0; m1_wdata = 0;
    s_gnt = 0; s_rvalid = 0; s_rdata = 0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_rr = 1; m_lk = 0; m_lkid = 0; m_err = 0;
  endtask

  task automatic do_reset();
    idle();
    HRESETn = 0;
    model_reset();
    @(posedge HCLK);
    @(posedge HCLK);
    #1 HRESETn = 1;
  endtask

  task automatic tick();
    bit sel, sreq;
    int qs;
    sel = msel();
    qs = mq.size();
    sreq = (sel ? m1_req : m0_req) && qs < MAXO;
    @(posedge HCLK);
    if (s_rvalid && qs == 0) m_err = 1;
    if (s_rvalid && qs > 0) mq.delete(0);
    if (sreq && s_gnt) begin
      mq.push_back(sel); m_rr = sel; m_lk = 0;
    end else if (sreq) begin
      m_lk = 1; m_lkid = sel;
    end else if (m_lk && !(m_lkid ? m1_req : m0_req)) m_lk = 0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    HRESETn = 0;
    model_reset();
    m0_req = 1; m1_req = 1; s_gnt = 1; s_rvalid = 1; s_rdata = 32'h1234;
    #2;
    total++; if ({s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 5'b0) begin bad++; $display("FAIL reset_ctl: got %b want 00000", {s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}); end
    total++; if ({m0_rdata, m1_rdata, s_addr} !== 96'h0) begin bad++; $display("FAIL reset_data: got %h want 0", {m0_rdata, m1_rdata, s_addr}); end
    do_reset();
    #4;
    total++; if ({outstanding, err_unexpected} !== 3'b0) begin bad++; $display("FAIL reset_state: got %b want 000", {outstanding, err_unexpected}); end
  endtask

  task automatic test_single_read();
    do_reset();
    m0_req = 1; m0_addr = 32'h0010_0010; s_gnt = 1;
    #4;
    total++; if ({s_req, m0_gnt, m1_gnt} !== 3'b110) begin bad++; $display("FAIL single_gnt: got %b want 110", {s_req, m0_gnt, m1_gnt}); end
    total++; if (s_addr !== 32'h0010_0010) begin bad++; $display("FAIL single_addr: got %h want 00100010", s_addr); end
    tick();
    m0_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'hDEAD_BEEF;
    #4;
    total++; if ({m0_rvalid, m0_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin bad++; $display("FAIL single_rsp: got %b %h want 1 deadbeef", m0_rvalid, m0_rdata); end
    total++; if ({m1_gnt, m1_rvalid, m1_rdata} !== 34'h0) begin bad++; $display("FAIL single_m1: got %h want 0", {m1_gnt, m1_rvalid, m1_rdata}); end
    tick();
    idle();
  endtask

  task automatic test_contention();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      m0_req = k < 4; m1_req = k < 4; s_gnt = 1;
      s_rvalid = k > 0; s_rdata = 32'h11 * k;
      #4;
      if (k < 4) begin
        total++; if ({m0_gnt, m1_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rr_gnt%0d: got %b", k, {m0_gnt, m1_gnt}); end
      end
      if (k > 0) begin
        total++;
        if ((k % 2 == 1) ? ({m0_rvalid, m1_rvalid, m0_rdata} !== {2'b10, 32'h11 * k}) : ({m0_rvalid, m1_rvalid, m1_rdata} !== {2'b01, 32'h11 * k})) begin
          bad++; $display("FAIL rr_rsp%0d: got %b%b %h %h want data %h", k, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, 32'h11 * k);
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_stall_lock();
    do_reset();
    m1_req = 1; m1_addr = 32'hA1A1_0004;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin m0_req = 1; m0_addr = 32'hB0B0_0008; end
      #4;
      total++; if ({s_req, m1_gnt, s_addr} !== {2'b10, 32'hA1A1_0004}) begin bad++; $display("FAIL lock_hold%0d: got %b %b %h", k, s_req, m1_gnt, s_addr); end
      tick();
    end
    s_gnt = 1;
    #4;
    total++; if ({m0_gnt, m1_gnt} !== 2'b01) begin bad++; $display("FAIL lock_first: got %b want 01", {m0_gnt, m1_gnt}); end
    tick();
    m1_req = 0;
    #4;
    total++; if ({m0_gnt, m1_gnt, s_addr} !== {2'b10, 32'hB0B0_0008}) begin bad++; $display("FAIL lock_second: got %b %h", {m0_gnt, m1_gnt}, s_addr); end
    tick();
    idle();
  endtask

  task automatic test_full_fifo();
    do_reset();
    m0_req = 1; s_gnt = 1;
    tick();
    tick();
    #4;
    total++; if ({s_req, m0_gnt, outstanding} !== 4'b0010) begin bad++; $display("FAIL full_block: got %b want 0010", {s_req, m0_gnt, outstanding}); end
    tick();
    s_rvalid = 1; s_rdata = 32'h55;
    #4;
    total++; if ({s_req, m0_rvalid, m0_rdata} !== {2'b01, 32'h55}) begin bad++; $display("FAIL full_strict: got %b %b %h", s_req, m0_rvalid, m0_rdata); end
    tick();
    s_rvalid = 0;
    #4;
    total++; if ({m0_gnt, outstanding} !== 3'b101) begin bad++; $display("FAIL full_regrant: got %b want 101", {m0_gnt, outstanding}); end
    tick();
    idle();
  endtask

  task automatic test_spurious();
    do_reset();
    s_rvalid = 1; s_rdata = 32'hBAD;
    #4;
    total++; if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== 66'h0) begin bad++; $display("FAIL spur_rv: got %b%b", m0_rvalid, m1_rvalid); end
    tick();
    s_rvalid = 0;
    #4;
    total++; if (err_unexpected !== 1'b1) begin bad++; $display("FAIL spur_err: got %b want 1", err_unexpected); end
    tick(); tick(); tick();
    total++; if ({err_unexpected, outstanding} !== 3'b100) begin bad++; $display("FAIL spur_sticky: got %b want 100", {err_unexpected, outstanding}); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    m1_req = 1; s_gnt = 1;
    tick();
    m1_req = 0; m0_req = 1;
    tick();
    m1_req = 1;
    #4;
    total++; if ({outstanding, s_req} !== 3'b100) begin bad++; $display("FAIL mid_full: got %b want 100", {outstanding, s_req}); end
    s_rvalid = 1; s_rdata = 32'h77;
    HRESETn = 0;
    model_reset();
    #1;
    total++; if ({outstanding, s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== 71'h0) begin bad++; $display("FAIL mid_flush: got %b %b", outstanding, {s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}); end
    @(posedge HCLK);
    #1 HRESETn = 1; s_rvalid = 0;
    #4;
    total++; if ({m0_gnt, m1_gnt} !== 2'b10) begin bad++; $display("FAIL mid_first: got %b want 10", {m0_gnt, m1_gnt}); end
    tick();
    idle();
  endtask

  task automatic test_random();
    exp_t e, o;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      m0_req = $urandom_range(0, 9) < 7; m1_req = $urandom_range(0, 9) < 6;
      m0_addr = $urandom; m1_addr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
      m0_we = 1'($urandom); m1_we = 1'($urandom); m0_be = 4'($urandom); m1_be = 4'($urandom);
      s_gnt = $urandom_range(0, 3) != 0;
      s_rvalid = mq.size() > 0 ? $urandom_range(0, 1) == 1 : $urandom_range(0, 49) == 0;
      s_rdata = $urandom;
      #4;
      e = model_out();
      o = {s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, s_addr, s_wdata, s_we, s_be, outstanding, err_unexpected};
      total++; if (o !== e) begin bad++; $display("FAIL rand%0d: got %h want %h", k, o, e); end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single_read();
    test_contention();
    test_stall_lock();
    test_full_fifo();
    test_spurious();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Two-master, one-slave arbiter that shares the data memory port between the RI5CY core data interface (m0) and an auxiliary requester (m1: DMA/SPI loader). It sits between the core/aux masters and the memory side of data_bus. Both sides use the req/gnt/rvalid protocol. It does round-robin arbitration on the address phase and tracks outstanding transactions in an ID FIFO so that each rvalid/rdata response is routed back to the master that issued it.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_OUTSTANDING, 2, max accepted-but-unanswered transactions (ID FIFO depth, >=1)

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
m0_req / m1_req  in  1  master request
m0_addr / m1_addr  in  ADDR_W  address
m0_we / m1_we  in  1  write enable
m0_be / m1_be  in  DATA_W/8  byte enables
m0_wdata / m1_wdata  in  DATA_W  write data
m0_gnt / m1_gnt  out  1  address-phase grant
m0_rvalid / m1_rvalid  out  1  response valid
m0_rdata / m1_rdata  out  DATA_W  read data
s_req  out  1  request to memory
s_addr, s_we, s_be, s_wdata  out  ADDR_W,1,DATA_W/8,DATA_W  muxed from the selected master
s_gnt  in  1  memory grant
s_rvalid  in  1  memory response valid
s_rdata  in  DATA_W  memory read data
outstanding  out  $clog2(MAX_OUTSTANDING+1)  in-flight transaction count
err_unexpected  out  1  sticky flag: s_rvalid arrived with empty ID FIFO

Behaviour:
- Clock HCLK; reset HRESETn is asynchronous and active-low. Reset state: FIFO empty, outstanding=0, lock=0, rr_last=1 (so m0 wins the first contest), err_unexpected=0. All gnt/rvalid/s_req outputs are 0 and all rdata outputs are 0.
- Selection (combinational):
  - If lock=1, sel=lock_id.
  - Otherwise, if exactly one master requests, sel is that master.
  - If both request, sel = !rr_last.
  - If neither requests, s_req=0.
- s_req = req[sel] & (outstanding < MAX_OUTSTANDING). When the FIFO is full, s_req is blocked strictly, even if s_rvalid is asserted in the same cycle.
- s_addr/we/be/wdata are taken from m[sel]. They are zero when s_req=0.
- m_gnt[i] = s_req & s_gnt & (sel==i). The grant is combinational, so there is no added latency.
- Handshake (s_req & s_gnt):
  - Push sel into the ID FIFO.
  - rr_last <= sel.
  - lock <= 0.
- Stall (s_req & !s_gnt): lock <= 1 and lock_id <= sel. The presented master stays selected until it is granted, so a master holding req is never preempted.
- If the locked master drops req (protocol violation), lock clears next cycle and normal arbitration resumes.
- Response path:
  - On s_rvalid, pop the FIFO head h. Assert m_rvalid[h] in the same cycle and drive m_rdata[h]=s_rdata. The other master's rdata is 0.
  - Responses are in order; there is no reordering.
- Simultaneous push and pop in one cycle leaves outstanding unchanged. Push at full cannot occur because it is blocked. Pop at empty is ignored, sets err_unexpected, and produces no m_rvalid.
- FIFO pointers wrap modulo MAX_OUTSTANDING.
- Reset mid-operation flushes the FIFO. The memory shares HRESETn, so no stale responses are expected.
- Back-to-back: with a 1-cycle memory (gnt same cycle, rvalid next), one transaction per cycle is sustained when MAX_OUTSTANDING>=2.

Decomposition:
- Package data_bus_pkg:
  - typedef master_id_t (1 bit)
  - constants NUM_MASTERS=2, M_CORE=0, M_AUX=1
  - shared width localparams
- Sub-module id_fifo: synchronous FIFO of master_id_t with DEPTH=MAX_OUTSTANDING, push/pop/full/empty/count, and asynchronous active-low reset.
- The arbiter FSM (lock, rr_last) and the muxing stay in data_mem_arbiter.

Test Plan:
1. Single master read: m0_req, addr 0x00100010. Memory grants immediately and returns rvalid next cycle with 0xDEADBEEF. Expect m0_gnt in cycle 0, m0_rvalid with 0xDEADBEEF in cycle 1, and m1 outputs all 0.
2. Contention: both masters request continuously for 4 grants. Expect grant order m0, m1, m0, m1, and responses routed to matching masters with rdata 0x11,0x22,0x33,0x44.
3. Stall lock: m1 requests alone with s_gnt=0 for 3 cycles, then m0 also requests. Expect m1 to stay selected with s_addr stable until s_gnt=1, m1 granted first, then m0.
4. Full FIFO: MAX_OUTSTANDING=2, memory withholds rvalid. Expect the third request to see s_req=0 while outstanding=2, then be granted the cycle after the first rvalid.
5. Spurious response: s_rvalid=1 with outstanding=0. Expect no m_rvalid, err_unexpected=1, which stays set until reset.
6. Reset mid-flight: assert HRESETn=0 with outstanding=2. Expect outstanding=0, lock cleared, all outputs 0 immediately, and m0 winning the first contest after reset.
